iter_multiplier: RTL

- Parametrised, multi-cycle, shift-add integer multiplier for the processor's multdiv unit.
- Successor to the 32-bit single-cycle combinational signed multiplier. Adds:
  - configurable width;
  - signed or unsigned mode per operation;
  - full double-width product;
  - mode-aware overflow;
  - start/done handshake with cancel.
- Sits between the decode/execute stage and the writeback mux. The pipeline stalls on in_ready low.

---
 rtl/iter_multiplier_if.sv | 27 ++
 rtl/iter_multiplier.sv | 124 ++++++++++++
 2 files changed

// File: rtl/iter_multiplier_if.sv
// Start/done handshake and operand/result bundle for the shift-add multiplier.
// The master side issues operations, the slave side is the multiplier itself.
interface iter_multiplier_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             cancel;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_lo;
   logic [WIDTH-1:0] product_hi;
   logic             overflow;

   modport master (
      output start, cancel, is_signed, a, b,
      input  in_ready, busy, done, product_lo, product_hi, overflow
   );

   modport slave (
      input  start, cancel, is_signed, a, b,
      output in_ready, busy, done, product_lo, product_hi, overflow
   );
endinterface

// File: rtl/iter_multiplier.sv
// Multi-cycle shift-add multiplier, one multiplier bit per clock, signed or
// unsigned per operation, full double-width product with mode-aware overflow.
//
// state  | meaning
// S_IDLE | waiting for start, holding last result
// S_RUN  | one iteration per edge on multiplier bit cnt_q (LSB first)
// S_DONE | result registered, done pulses for this single cycle
module iter_multiplier #(
   parameter int WIDTH = 32
) (
   input logic              clock,
   input logic              reset_n,
   iter_multiplier_if.slave mul
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH:0]   acc_q;
   logic [2*WIDTH:0]   acc_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               sgn_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   hi_q;
   logic               ovf_q;
   logic               done_q;
   logic               busy_q;
   logic               rdy_q;

   logic [WIDTH-1:0]   pp;
   logic [WIDTH:0]     term;
   logic [WIDTH:0]     upper_sum;
   logic [2*WIDTH+1:0] acc_sum;
   logic               ovf_d;

   // b_q shifts right each iteration, so b_q[0] is always multiplier bit cnt_q.
   always_comb begin
      pp        = a_q & {WIDTH{b_q[0]}};
      term      = sgn_q ? {pp[WIDTH-1], pp} : {1'b0, pp};
      if (sgn_q && (cnt_q == LAST_IT)) begin
         upper_sum = acc_q[2*WIDTH:WIDTH] - term;
      end else begin
         upper_sum = acc_q[2*WIDTH:WIDTH] + term;
      end
      acc_sum   = {sgn_q & upper_sum[WIDTH], upper_sum, acc_q[WIDTH-1:0]};
      acc_d     = (2*WIDTH+1)'(acc_sum >> 1);
      if (sgn_q) begin
         ovf_d = ~((&acc_d[2*WIDTH-1:WIDTH-1]) | ~(|acc_d[2*WIDTH-1:WIDTH-1]));
      end else begin
         ovf_d = |acc_d[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (mul.start) begin
                  a_q     <= mul.a;
                  b_q     <= mul.b;
                  sgn_q   <= mul.is_signed;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  rdy_q   <= 1'b0;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (mul.cancel) begin
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= acc_d;
                  b_q   <= b_q >> 1;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_IT) begin
                     lo_q    <= acc_d[WIDTH-1:0];
                     hi_q    <= acc_d[2*WIDTH-1:WIDTH];
                     ovf_q   <= ovf_d;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     rdy_q   <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               rdy_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mul.in_ready   = rdy_q;
   assign mul.busy       = busy_q;
   assign mul.done       = done_q;
   assign mul.product_lo = lo_q;
   assign mul.product_hi = hi_q;
   assign mul.overflow   = ovf_q;
endmodule
